// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : router_pkg
//  Purpose  : Shared router constants: flit geometry, direction codes and the
//             direction-to-output-port mapping used by the switch allocator.
//  Revision : 1.0  initial release
// ============================================================================
package router_pkg;

  localparam int FLIT_SIZE = 82;
  localparam int VALID_BIT = FLIT_SIZE - 1;
  localparam int ROUTE_LEN = 3;

  // Direction codes produced by route_comp. Codes 1..6 map onto network
  // output ports 0..5 (XPOS,YPOS,ZPOS,XNEG,YNEG,ZNEG).
  typedef enum logic [ROUTE_LEN-1:0] {
    DIR_INJECT = 3'd0,
    DIR_XPOS   = 3'd1,
    DIR_YPOS   = 3'd2,
    DIR_ZPOS   = 3'd3,
    DIR_XNEG   = 3'd4,
    DIR_YNEG   = 3'd5,
    DIR_ZNEG   = 3'd6,
    DIR_EJECT  = 3'd7
  } dir_e;

  // Network direction code to output port index (valid for codes 1..6).
  function automatic logic [ROUTE_LEN-1:0] dir2port(input logic [ROUTE_LEN-1:0] dir);
    return dir - 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/switch_alloc_core_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Round-robin arbiter. Searches i_req starting at the internal
//             pointer, issues a one-hot grant when i_en is high, and moves the
//             pointer to winner+1 (mod N) only when a grant is issued.
//  Ports    : clk, rst (sync, active high), i_en (target can accept),
//             i_req[N] requests, o_gnt[N] one-hot grant (combinational).
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter
  import router_pkg::*;
#(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_win;
  logic          w_any;
  logic [N-1:0]  w_gnt;

  // Linear search over ptr, ptr+1, ... wrapping at N. The index sum needs one
  // extra bit because ptr+i can reach 2N-2 before the wrap subtraction.
  always_comb begin : p_search
    logic [PW:0] w_idx;
    w_gnt = '0;
    w_win = '0;
    w_any = 1'b0;
    w_idx = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = {1'b0, r_ptr} + (PW+1)'(i);
      if (w_idx >= (PW+1)'(N)) begin
        w_idx = w_idx - (PW+1)'(N);
      end
      if (i_en && !w_any && i_req[w_idx[PW-1:0]]) begin
        w_any = 1'b1;
        w_win = w_idx[PW-1:0];
      end
    end
    if (w_any) begin
      w_gnt[w_win] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= (w_win == PW'(N-1)) ? '0 : w_win + 1'b1;
    end
  end

  assign o_gnt = w_gnt;

endmodule
`default_nettype wire

// File: rtl/switch_alloc_core.sv
`default_nettype none
// ============================================================================
//  Module   : switch_alloc_core
//  Purpose  : Multi-port input-queue and switch-allocation stage. Each input
//             port has a FIFO; the FIFO head requests one network output, the
//             eject port, or is dropped (DIR_INJECT). Each target has a
//             round-robin arbiter; winners load registered output stages with
//             valid/ready backpressure.
//  Config   : CREDIT_FC_EN - adds credit_ret and per-output credit counters.
//  Ports    : clk, rst (sync, active high)
//             in_flit/in_route/in_valid/in_full : per-port input side
//             out_flit/out_valid/out_ready      : per-port network outputs
//             eject_flit/eject_valid/eject_ready: local eject output
//             credit_ret (CREDIT_FC_EN only)    : credit return pulses
//             overflow_err (sticky), drop_cnt (saturating)
//  Revision : 1.0  initial release
// ============================================================================
module switch_alloc_core
  import router_pkg::*;
#(
  parameter int PORT_NUM = 6,
  parameter int Q_ADDR   = 3
`ifdef CREDIT_FC_EN
  ,
  parameter int CREDIT_INIT = 8
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORT_NUM*FLIT_SIZE-1:0] in_flit,
  input  logic [PORT_NUM*ROUTE_LEN-1:0] in_route,
  input  logic [PORT_NUM-1:0]           in_valid,
  output logic [PORT_NUM-1:0]           in_full,
  output logic [PORT_NUM*FLIT_SIZE-1:0] out_flit,
  output logic [PORT_NUM-1:0]           out_valid,
  input  logic [PORT_NUM-1:0]           out_ready,
  output logic [FLIT_SIZE-1:0]          eject_flit,
  output logic                          eject_valid,
  input  logic                          eject_ready,
`ifdef CREDIT_FC_EN
  input  logic [PORT_NUM-1:0]           credit_ret,
`endif
  output logic [PORT_NUM-1:0]           overflow_err,
  output logic [15:0]                   drop_cnt
);

  localparam int DEPTH = 2**Q_ADDR;
  localparam int NT    = PORT_NUM + 1;   // network outputs plus eject
  localparam int EJ    = PORT_NUM;       // target index of the eject port
  localparam int NW    = $clog2(PORT_NUM + 1);

  // Input FIFO storage and state
  logic [FLIT_SIZE-1:0] r_mem  [PORT_NUM][DEPTH];
  logic [ROUTE_LEN-1:0] r_dmem [PORT_NUM][DEPTH];
  logic [Q_ADDR-1:0]    r_wr   [PORT_NUM];
  logic [Q_ADDR-1:0]    r_rd   [PORT_NUM];
  logic [Q_ADDR:0]      r_cnt  [PORT_NUM];
  logic [PORT_NUM-1:0]  r_ovf;
  logic [15:0]          r_drop;

  // Output registers, index EJ is the eject stage
  logic [FLIT_SIZE-1:0] r_oflit [NT];
  logic [NT-1:0]        r_ovalid;

  logic [PORT_NUM-1:0]  w_full;
  logic [PORT_NUM-1:0]  w_empty;
  logic [PORT_NUM-1:0]  w_wr;
  logic [PORT_NUM-1:0]  w_pop;
  logic [PORT_NUM-1:0]  w_drop;
  logic [FLIT_SIZE-1:0] w_head [PORT_NUM];
  logic [ROUTE_LEN-1:0] w_hdir [PORT_NUM];
  logic [PORT_NUM-1:0]  w_req  [NT];
  logic [PORT_NUM-1:0]  w_gnt  [NT];
  logic [FLIT_SIZE-1:0] w_win  [NT];
  logic [NT-1:0]        w_rdy;
  logic [NT-1:0]        w_free;
  logic [NT-1:0]        w_load;
  logic [NT-1:0]        w_cred_ok;
  logic [NW-1:0]        w_drop_num;
  logic [16:0]          w_drop_sum;

  // --------------------------------------------------------------------------
  // FIFO status. Full is derived from the count only, so a pop in the same
  // cycle never lets a write into a full FIFO.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int p = 0; p < PORT_NUM; p++) begin
      w_full[p]  = (r_cnt[p] == (Q_ADDR+1)'(DEPTH));
      w_empty[p] = (r_cnt[p] == '0);
      w_wr[p]    = in_valid[p] & ~w_full[p];
      w_head[p]  = r_mem[p][r_rd[p]];
      w_hdir[p]  = r_dmem[p][r_rd[p]];
    end
  end

  // --------------------------------------------------------------------------
  // Head decode: every non-empty head raises exactly one request or a drop.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int t = 0; t < NT; t++) begin
      w_req[t] = '0;
    end
    w_drop = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      if (!w_empty[p]) begin
        case (w_hdir[p])
          DIR_INJECT: w_drop[p] = 1'b1;
          DIR_EJECT:  w_req[EJ][p] = 1'b1;
          default:    w_req[dir2port(w_hdir[p])][p] = 1'b1;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Credit flow control
  // --------------------------------------------------------------------------
`ifdef CREDIT_FC_EN
  localparam int CW = $clog2(CREDIT_INIT + 1);

  logic [CW-1:0] r_cred [PORT_NUM];

  always_comb begin
    for (int o = 0; o < PORT_NUM; o++) begin
      w_cred_ok[o] = (r_cred[o] != '0);
    end
    w_cred_ok[EJ] = 1'b1;  // eject is not credit-controlled
  end

  // Grant and return in the same cycle cancel; returns beyond the initial
  // allowance are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < PORT_NUM; o++) begin
        r_cred[o] <= CW'(CREDIT_INIT);
      end
    end else begin
      for (int o = 0; o < PORT_NUM; o++) begin
        case ({w_load[o], credit_ret[o]})
          2'b10:   r_cred[o] <= r_cred[o] - 1'b1;
          2'b01:   if (r_cred[o] != CW'(CREDIT_INIT)) r_cred[o] <= r_cred[o] + 1'b1;
          default: r_cred[o] <= r_cred[o];
        endcase
      end
    end
  end
`else
  assign w_cred_ok = '1;
`endif

  // A target can take a new flit when its register is empty or draining now.
  assign w_rdy  = {eject_ready, out_ready};
  assign w_free = (~r_ovalid | w_rdy) & w_cred_ok;

  // --------------------------------------------------------------------------
  // One arbiter per target (PORT_NUM network outputs + eject)
  // --------------------------------------------------------------------------
  for (genvar t = 0; t < NT; t++) begin : g_arb
    rr_arbiter #(
      .N (PORT_NUM)
    ) u_arb (
      .clk   (clk),
      .rst   (rst),
      .i_en  (w_free[t]),
      .i_req (w_req[t]),
      .o_gnt (w_gnt[t])
    );
  end

  // Winner mux and pops. Each input requests a single target, so at most one
  // grant per input per cycle and the OR-mux is conflict free.
  always_comb begin
    w_pop = w_drop;
    for (int t = 0; t < NT; t++) begin
      w_win[t]  = '0;
      w_load[t] = |w_gnt[t];
      for (int p = 0; p < PORT_NUM; p++) begin
        if (w_gnt[t][p]) begin
          w_win[t] = w_win[t] | w_head[p];
          w_pop[p] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_drop_num = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      w_drop_num = w_drop_num + NW'(w_drop[p]);
    end
    w_drop_sum = {1'b0, r_drop} + 17'(w_drop_num);
  end

  // --------------------------------------------------------------------------
  // FIFO storage (no reset needed: pointers/counts define the contents)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int p = 0; p < PORT_NUM; p++) begin
      if (w_wr[p]) begin
        r_mem[p][r_wr[p]]  <= in_flit[p*FLIT_SIZE +: FLIT_SIZE];
        r_dmem[p][r_wr[p]] <= in_route[p*ROUTE_LEN +: ROUTE_LEN];
      end
    end
  end

  // --------------------------------------------------------------------------
  // FIFO control, error/drop bookkeeping and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < PORT_NUM; p++) begin
        r_wr[p]  <= '0;
        r_rd[p]  <= '0;
        r_cnt[p] <= '0;
      end
      for (int t = 0; t < NT; t++) begin
        r_oflit[t] <= '0;
      end
      r_ovalid <= '0;
      r_ovf    <= '0;
      r_drop   <= '0;
    end else begin
      for (int p = 0; p < PORT_NUM; p++) begin
        if (w_wr[p]) begin
          r_wr[p] <= r_wr[p] + 1'b1;
        end
        if (w_pop[p]) begin
          r_rd[p] <= r_rd[p] + 1'b1;
        end
        case ({w_wr[p], w_pop[p]})
          2'b10:   r_cnt[p] <= r_cnt[p] + 1'b1;
          2'b01:   r_cnt[p] <= r_cnt[p] - 1'b1;
          default: r_cnt[p] <= r_cnt[p];
        endcase
        if (in_valid[p] && w_full[p]) begin
          r_ovf[p] <= 1'b1;
        end
      end
      for (int t = 0; t < NT; t++) begin
        if (w_load[t]) begin
          r_oflit[t]  <= w_win[t];
          r_ovalid[t] <= 1'b1;
        end else if (w_rdy[t]) begin
          r_ovalid[t] <= 1'b0;
        end
      end
      r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  for (genvar o = 0; o < PORT_NUM; o++) begin : g_out
    assign out_flit[o*FLIT_SIZE +: FLIT_SIZE] = r_oflit[o];
  end

  assign out_valid    = r_ovalid[PORT_NUM-1:0];
  assign eject_flit   = r_oflit[EJ];
  assign eject_valid  = r_ovalid[EJ];
  assign in_full      = w_full;
  assign overflow_err = r_ovf;
  assign drop_cnt     = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_switch_alloc_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_switch_alloc_core
//  Purpose  : Directed self-checking bench for switch_alloc_core.
//  Revision : 1.0  initial release
// ============================================================================
module tb_switch_alloc_core;
  import router_pkg::*;

  localparam int P  = 6;
  localparam int FW = FLIT_SIZE;

  logic            clk;
  logic            rst;
  logic [P*FW-1:0] in_flit;
  logic [P*3-1:0]  in_route;
  logic [P-1:0]    in_valid;
  logic [P-1:0]    in_full;
  logic [P*FW-1:0] out_flit;
  logic [P-1:0]    out_valid;
  logic [P-1:0]    out_ready;
  logic [FW-1:0]   eject_flit;
  logic            eject_valid;
  logic            eject_ready;
  logic [P-1:0]    overflow_err;
  logic [15:0]     drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef CREDIT_FC_EN
  logic         auto_ret = 1'b1;
  logic [P-1:0] man_ret  = '0;
  logic [P-1:0] credit_ret;
  assign credit_ret = auto_ret ? (out_valid & out_ready) : man_ret;
`endif

  switch_alloc_core #(
    .PORT_NUM (P),
    .Q_ADDR   (3)
`ifdef CREDIT_FC_EN
    ,
    .CREDIT_INIT (2)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_flit      (in_flit),
    .in_route     (in_route),
    .in_valid     (in_valid),
    .in_full      (in_full),
    .out_flit     (out_flit),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .eject_flit   (eject_flit),
    .eject_valid  (eject_valid),
    .eject_ready  (eject_ready),
`ifdef CREDIT_FC_EN
    .credit_ret   (credit_ret),
`endif
    .overflow_err (overflow_err),
    .drop_cnt     (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] mk(input int src, input int seq);
    logic [7:0] s8;
    logic [7:0] q8;
    s8 = src[7:0];
    q8 = seq[7:0];
    return {1'b1, 65'd0, q8, s8};
  endfunction

  function automatic logic [FW-1:0] get_out(input int o);
    return out_flit[o*FW +: FW];
  endfunction

  task automatic set_in(input int p, input logic [FW-1:0] f, input logic [2:0] d);
    in_flit[p*FW +: FW] = f;
    in_route[p*3 +: 3]  = d;
    in_valid[p]         = 1'b1;
  endtask

  initial begin
    int srcs [3];
    srcs[0] = 0; srcs[1] = 2; srcs[2] = 4;

    rst = 1'b1; in_flit = '0; in_route = '0; in_valid = '0;
    out_ready = '1; eject_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_eject_valid", eject_valid, 0);
    check("rst_in_full", in_full, 0);
    check("rst_overflow", overflow_err, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_out_flit", out_flit, 0);

    // 1: single flit port0 -> YPOS (output 1), valid two edges later
    set_in(0, mk(0, 8'h11), 3'd2);
    tick();
    in_valid = '0;
    check("t1_not_yet", out_valid, 0);
    tick();
    check("t1_valid", out_valid, 6'b000010);
    check("t1_flit", get_out(1), mk(0, 8'h11));
    check("t1_eject_idle", eject_valid, 0);
    tick();
    check("t1_drained", out_valid, 0);

    // 2: ports 0,2,4 all to XPOS every cycle, strict rotation 0,2,4,...
    set_in(0, mk(0, 0), 3'd1);
    set_in(2, mk(2, 0), 3'd1);
    set_in(4, mk(4, 0), 3'd1);
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c >= 2 && c - 2 < 18) begin
        check("t2_valid", out_valid[0], 1);
        check("t2_rr_flit", get_out(0), mk(srcs[(c-2)%3], (c-2)/3));
      end
      if (c == 20) check("t2_idle", out_valid[0], 0);
      if (c < 6) begin
        set_in(0, mk(0, c), 3'd1);
        set_in(2, mk(2, c), 3'd1);
        set_in(4, mk(4, c), 3'd1);
      end else begin
        in_valid = '0;
      end
    end

    // 3: stalled output 3, 10 writes on port1 -> full, overflow, lossless drain
    out_ready[3] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_in(1, mk(1, i), 3'd4);
      tick();
      if (i == 7) check("t3_not_full", in_full[1], 0);
      if (i == 8) begin
        check("t3_full", in_full[1], 1);
        check("t3_no_ovf_yet", overflow_err, 0);
      end
    end
    in_valid = '0;
    check("t3_overflow", overflow_err, 6'b000010);
    check("t3_stall_valid", out_valid[3], 1);
    check("t3_stall_flit", get_out(3), mk(1, 0));
    out_ready[3] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("t3_drain_valid", out_valid[3], 1);
      check("t3_drain_flit", get_out(3), mk(1, k));
    end
    tick();
    check("t3_drain_done", out_valid[3], 0);
    check("t3_full_clear", in_full[1], 0);

    // 4: eject from ports 0 and 5, plus a DIR_INJECT drop on port 2
    set_in(0, mk(0, 8'h40), 3'd7);
    set_in(5, mk(5, 8'h41), 3'd7);
    set_in(2, mk(2, 8'h42), 3'd0);
    tick();
    in_valid = '0;
    tick();
    check("t4_ej_valid0", eject_valid, 1);
    check("t4_ej_flit0", eject_flit, mk(0, 8'h40));
    check("t4_drop_cnt", drop_cnt, 1);
    check("t4_no_out", out_valid, 0);
    tick();
    check("t4_ej_valid1", eject_valid, 1);
    check("t4_ej_flit1", eject_flit, mk(5, 8'h41));
    tick();
    check("t4_ej_done", eject_valid, 0);
    check("t4_no_out_end", out_valid, 0);

    // 6: reset with queued flits and a held output
    out_ready[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(3, mk(3, 8'h60 + i), 3'd3);
      tick();
    end
    in_valid = '0;
    check("t6_held", out_valid[2], 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_out_valid", out_valid, 0);
    check("t6_out_flit", out_flit, 0);
    check("t6_eject", eject_valid, 0);
    check("t6_in_full", in_full, 0);
    check("t6_overflow", overflow_err, 0);
    check("t6_drop_cnt", drop_cnt, 0);
    out_ready = '1;
    tick();
    check("t6_fifo_empty_a", out_valid, 0);
    tick();
    check("t6_fifo_empty_b", out_valid, 0);
    // pointer back at 0: port1 must beat port5 on output 0
    set_in(1, mk(1, 8'h70), 3'd1);
    set_in(5, mk(5, 8'h71), 3'd1);
    tick();
    in_valid = '0;
    tick();
    check("t6_ptr_first", get_out(0), mk(1, 8'h70));
    tick();
    check("t6_ptr_second", get_out(0), mk(5, 8'h71));
    tick();

`ifdef CREDIT_FC_EN
    // 5: two credits -> two flits, then one return -> exactly one more
    rst = 1'b1;
    auto_ret = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(0, mk(0, 8'h50 + i), 3'd1);
      tick();
      if (i == 1) check("t5_flit0", get_out(0), mk(0, 8'h50));
      if (i == 2) check("t5_flit1", get_out(0), mk(0, 8'h51));
      if (i == 3) check("t5_stall", out_valid[0], 0);
    end
    in_valid = '0;
    man_ret[0] = 1'b1;
    tick();
    man_ret[0] = 1'b0;
    check("t5_ret_no_grant", out_valid[0], 0);
    tick();
    check("t5_one_more_v", out_valid[0], 1);
    check("t5_one_more_f", get_out(0), mk(0, 8'h52));
    tick();
    check("t5_stall_again_a", out_valid[0], 0);
    tick();
    check("t5_stall_again_b", out_valid[0], 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
